// File: rtl/shift_counter_if.sv
// Control and status bundle for shift_counter_param: step/load/mode controls in,
// counter state, terminal count, error pulse and wrap count out.
interface shift_counter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic         en;
    logic         mode;
    logic         dir;
    logic         load;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         tc;
    logic         err;
    logic [W-1:0] wraps;

    modport master (
        output en, mode, dir, load, d,
        input  q, tc, err, wraps
    );

    modport slave (
        input  en, mode, dir, load, d,
        output q, tc, err, wraps
    );
endinterface

// File: rtl/shift_counter_param.sv
// N-bit ring/Johnson shift counter with parallel load, illegal-state self-correction,
// terminal-count flag and a modulo-2^W count of completed periods.
module shift_counter_param #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input logic            clk,
    input logic            clr,
    shift_counter_if.slave bus
);

    logic [N-1:0] q_q;
    logic         mode_q;
    logic         err_q;
    logic [W-1:0] wraps_q;

    logic [N-1:0] step_q;
    logic         legal_q;
    logic         legal_d;
    logic         tc;

    function automatic logic [N-1:0] init_of(input logic m);
        return m ? '0 : N'(1);
    endfunction

    // Johnson legality: at most one 0/1 boundary between adjacent bits.
    function automatic logic is_legal(input logic [N-1:0] v, input logic m);
        int unsigned edges;
        edges = 0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        return m ? (edges <= 1) : ($countones(v) == 1);
    endfunction

    function automatic logic [N-1:0] step_of(input logic [N-1:0] v, input logic m,
                                             input logic dr);
        logic [N-1:0] r;
        if (!dr) r = {v[N-2:0], m ? ~v[N-1] : v[N-1]};
        else     r = {m ? ~v[0] : v[0], v[N-1:1]};
        return r;
    endfunction

    always_comb begin
        step_q  = step_of(q_q, mode_q, bus.dir);
        legal_q = is_legal(q_q, mode_q);
        legal_d = is_legal(bus.d, bus.mode);
        tc      = bus.en & ~bus.load & (bus.mode == mode_q) & legal_q
                  & (step_q == init_of(bus.mode));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q     <= init_of(bus.mode);
            mode_q  <= bus.mode;
            wraps_q <= '0;
            err_q   <= 1'b0;
        end else if (bus.mode != mode_q) begin
            // A mode change restarts the sequence; pending en/load are dropped.
            q_q    <= init_of(bus.mode);
            mode_q <= bus.mode;
            err_q  <= 1'b0;
        end else if (bus.load) begin
            q_q   <= legal_d ? bus.d : init_of(bus.mode);
            err_q <= ~legal_d;
        end else if (bus.en) begin
            if (!legal_q) begin
                q_q   <= init_of(bus.mode);
                err_q <= 1'b1;
            end else begin
                q_q   <= step_q;
                err_q <= 1'b0;
                if (tc) wraps_q <= wraps_q + W'(1);
            end
        end else begin
            err_q <= 1'b0;
        end
    end

    assign bus.q     = q_q;
    assign bus.tc    = tc;
    assign bus.err   = err_q;
    assign bus.wraps = wraps_q;

endmodule

// File: tb/tb_shift_counter_param.sv
// Directed scoreboard bench: expected q/err/wraps are queued when each step is driven
// and compared one clock later; tc is checked combinationally before each edge.
module tb_shift_counter_param;

    logic clk = 1'b0;
    logic clr_a = 1'b1;
    logic clr_b = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_counter_if #(.N(4), .W(8)) bus_a ();
    shift_counter_if #(.N(3), .W(2)) bus_b ();

    shift_counter_param #(.N(4), .W(8)) u_a (.clk(clk), .clr(clr_a), .bus(bus_a));
    shift_counter_param #(.N(3), .W(2)) u_b (.clk(clk), .clr(clr_b), .bus(bus_b));

    typedef struct {
        string       tag;
        logic [3:0]  q;
        logic        err;
        logic [7:0]  wraps;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp_a();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, " q"}, 32'(bus_a.q), 32'(e.q));
        chk({e.tag, " err"}, 32'(bus_a.err), 32'(e.err));
        chk({e.tag, " wraps"}, 32'(bus_a.wraps), 32'(e.wraps));
    endtask

    // One clock of stimulus on DUT A; tc is only checked when clr is low.
    task automatic step_a(input string tag, input logic clr, input logic en, input logic mode,
                          input logic dir, input logic load, input logic [3:0] d,
                          input logic exp_tc, input logic [3:0] eq, input logic ee,
                          input logic [7:0] ew);
        exp_t e;
        @(negedge clk);
        clr_a      = clr;
        bus_a.en   = en;
        bus_a.mode = mode;
        bus_a.dir  = dir;
        bus_a.load = load;
        bus_a.d    = d;
        #1;
        if (!clr) chk({tag, " tc"}, 32'(bus_a.tc), 32'(exp_tc));
        e.tag = tag; e.q = eq; e.err = ee; e.wraps = ew;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_cmp_a();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] ring3 [3];
        exp_t e;
        ring3[0] = 3'b001; ring3[1] = 3'b010; ring3[2] = 3'b100;

        bus_a.en = 0; bus_a.mode = 0; bus_a.dir = 0; bus_a.load = 0; bus_a.d = '0;
        bus_b.en = 0; bus_b.mode = 0; bus_b.dir = 0; bus_b.load = 0; bus_b.d = '0;

        // T1: ring, shift toward MSB, one full period
        step_a("t1 rst",  1, 0, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd0);
        step_a("t1 s1",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 8'd0);
        step_a("t1 s2",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0100, 0, 8'd0);
        step_a("t1 s3",   0, 1, 0, 0, 0, 4'h0, 0, 4'b1000, 0, 8'd0);
        step_a("t1 s4",   0, 1, 0, 0, 0, 4'h0, 1, 4'b0001, 0, 8'd1);
        step_a("t1 dir1", 0, 1, 0, 1, 0, 4'h0, 0, 4'b1000, 0, 8'd1);
        // load wins over en, so tc stays low even though a step would wrap
        step_a("t1 ldtc", 0, 1, 0, 0, 1, 4'b0010, 0, 4'b0010, 0, 8'd1);

        // T2: Johnson both directions
        step_a("t2 rst",  1, 0, 1, 0, 0, 4'h0, 0, 4'b0000, 0, 8'd0);
        step_a("t2 u1",   0, 1, 1, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd0);
        step_a("t2 u2",   0, 1, 1, 0, 0, 4'h0, 0, 4'b0011, 0, 8'd0);
        step_a("t2 u3",   0, 1, 1, 0, 0, 4'h0, 0, 4'b0111, 0, 8'd0);
        step_a("t2 u4",   0, 1, 1, 0, 0, 4'h0, 0, 4'b1111, 0, 8'd0);
        step_a("t2 u5",   0, 1, 1, 0, 0, 4'h0, 0, 4'b1110, 0, 8'd0);
        step_a("t2 u6",   0, 1, 1, 0, 0, 4'h0, 0, 4'b1100, 0, 8'd0);
        step_a("t2 u7",   0, 1, 1, 0, 0, 4'h0, 0, 4'b1000, 0, 8'd0);
        step_a("t2 u8",   0, 1, 1, 0, 0, 4'h0, 1, 4'b0000, 0, 8'd1);
        step_a("t2 d1",   0, 1, 1, 1, 0, 4'h0, 0, 4'b1000, 0, 8'd1);
        step_a("t2 d2",   0, 1, 1, 1, 0, 4'h0, 0, 4'b1100, 0, 8'd1);
        step_a("t2 d3",   0, 1, 1, 1, 0, 4'h0, 0, 4'b1110, 0, 8'd1);
        step_a("t2 d4",   0, 1, 1, 1, 0, 4'h0, 0, 4'b1111, 0, 8'd1);
        step_a("t2 d5",   0, 1, 1, 1, 0, 4'h0, 0, 4'b0111, 0, 8'd1);
        step_a("t2 d6",   0, 1, 1, 1, 0, 4'h0, 0, 4'b0011, 0, 8'd1);
        step_a("t2 d7",   0, 1, 1, 1, 0, 4'h0, 0, 4'b0001, 0, 8'd1);
        step_a("t2 d8",   0, 1, 1, 1, 0, 4'h0, 1, 4'b0000, 0, 8'd2);

        // T3: legal and illegal loads
        step_a("t3 rst",  1, 0, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd0);
        step_a("t3 bad",  0, 0, 0, 0, 1, 4'b0110, 0, 4'b0001, 1, 8'd0);
        step_a("t3 idle", 0, 0, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd0);
        step_a("t3 good", 0, 0, 0, 0, 1, 4'b0100, 0, 4'b0100, 0, 8'd0);
        step_a("t3 mchg", 0, 0, 1, 0, 1, 4'b0101, 0, 4'b0000, 0, 8'd0);
        step_a("t3 jbad", 0, 0, 1, 0, 1, 4'b0101, 0, 4'b0000, 1, 8'd0);
        step_a("t3 jok",  0, 0, 1, 0, 1, 4'b0111, 0, 4'b0111, 0, 8'd0);

        // T4: mode switch mid-count keeps wraps, ignores en
        step_a("t4 rst",  1, 0, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd0);
        step_a("t4 s1",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 8'd0);
        step_a("t4 s2",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0100, 0, 8'd0);
        step_a("t4 s3",   0, 1, 0, 0, 0, 4'h0, 0, 4'b1000, 0, 8'd0);
        step_a("t4 s4",   0, 1, 0, 0, 0, 4'h0, 1, 4'b0001, 0, 8'd1);
        step_a("t4 s5",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 8'd1);
        step_a("t4 s6",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0100, 0, 8'd1);
        step_a("t4 mchg", 0, 1, 1, 0, 0, 4'h0, 0, 4'b0000, 0, 8'd1);
        step_a("t4 next", 0, 1, 1, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd1);

        // T5: clr with en mid-sequence discards state and wraps
        step_a("t5 rst",  1, 0, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd0);
        step_a("t5 s1",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 8'd0);
        step_a("t5 s2",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0100, 0, 8'd0);
        step_a("t5 s3",   0, 1, 0, 0, 0, 4'h0, 0, 4'b1000, 0, 8'd0);
        step_a("t5 s4",   0, 1, 0, 0, 0, 4'h0, 1, 4'b0001, 0, 8'd1);
        step_a("t5 s5",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0010, 0, 8'd1);
        step_a("t5 s6",   0, 1, 0, 0, 0, 4'h0, 0, 4'b0100, 0, 8'd1);
        step_a("t5 clr",  1, 1, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 8'd0);

        // T6: N=3, W=2 ring; wraps counts modulo 4
        @(negedge clk);
        clr_b = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 rst q", 32'(bus_b.q), 32'(3'b001));
        chk("t6 rst wraps", 32'(bus_b.wraps), 32'(0));
        for (int s = 1; s <= 12; s++) begin
            @(negedge clk);
            clr_b    = 1'b0;
            bus_b.en = 1'b1;
            #1;
            chk($sformatf("t6 tc%0d", s), 32'(bus_b.tc),
                32'(ring3[(s - 1) % 3] == 3'b100));
            e.tag = $sformatf("t6 s%0d", s);
            e.q = {1'b0, ring3[s % 3]};
            e.err = 1'b0;
            e.wraps = 8'((s / 3) % 4);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.tag, " q"}, 32'(bus_b.q), 32'(e.q));
            chk({e.tag, " wraps"}, 32'(bus_b.wraps), 32'(e.wraps));
        end

        chk("sb empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
